// File: rtl/lapido_defs.sv
// Shared core_lapido definitions: datapath widths, write-back selects,
// flag bit positions and the memory-stage FSM encoding.
package lapido_defs;

  localparam int GPR_WIDTH           = 16;
  localparam int PC_WIDTH            = 16;
  localparam int GRP_ADDR_WIDTH      = 4;
  localparam int DATA_MEM_ADDR_WIDTH = 16;
  localparam int NUM_FLAGS           = 6;

  localparam logic [1:0] WB_RES_ALU = 2'd0;
  localparam logic [1:0] WB_RES_MEM = 2'd1;
  localparam logic [1:0] WB_RES_PC  = 2'd2;
  localparam logic [1:0] WB_RES_IMM = 2'd3;

  localparam int FLAG_FALSE    = 0;
  localparam int FLAG_TRUE     = 1;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_NEG      = 3;
  localparam int FLAG_ZERO     = 4;
  localparam int FLAG_CARRY    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage; the stage is the master, memory the slave.
// Handshake: the master raises req with we/addr/wdata and holds all four stable
// until a cycle in which ready is 1; that cycle completes the access and rdata is
// valid in it. ready sampled while req is 0 has no meaning.
interface mem_stage_if;
  import lapido_defs::*;

  logic                           req;
  logic                           we;
  logic [DATA_MEM_ADDR_WIDTH-1:0] addr;
  logic [GPR_WIDTH-1:0]           wdata;
  logic [GPR_WIDTH-1:0]           rdata;
  logic                           ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/branch_resolve.sv
// Branch condition evaluation: beq/bne on the zero flag, jt/jf on a selected flag.
module branch_resolve
  import lapido_defs::*;
(
  input  logic [NUM_FLAGS-1:0]      flags,
  input  logic [GRP_ADDR_WIDTH-1:0] flag_code,
  input  logic                      sel_jflag_branch,
  input  logic                      sel_jt_jf,
  input  logic                      sel_beq_bne,
  output logic                      cond
);

  localparam logic [GRP_ADDR_WIDTH-1:0] MAX_FLAG_CODE = GRP_ADDR_WIDTH'(FLAG_CARRY);

  logic flag_sel;

  // Codes beyond the carry position name no flag and read as 0.
  always_comb begin
    flag_sel = 1'b0;
    if (flag_code <= MAX_FLAG_CODE) begin
      flag_sel = flags[flag_code[2:0]];
    end
  end

  always_comb begin
    if (sel_jflag_branch) begin
      cond = flag_sel ^ sel_jt_jf;
    end else begin
      cond = flags[FLAG_ZERO] ^ sel_beq_bne;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// core_lapido memory stage: branch resolution, data-memory access FSM and the
// MEM/WB register. Optional wait-state timeout under `MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import lapido_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_write_enable,
  input  logic                      sel_beq_bne,
  input  logic                      sel_jt_jf,
  input  logic                      is_branch,
  input  logic                      sel_jflag_branch,
  input  logic [1:0]                wb_res_mux,
  input  logic                      reg_write_enable,
  input  logic [PC_WIDTH-1:0]       branch_addr,
  input  logic [PC_WIDTH-1:0]       next_pc,
  input  logic [GPR_WIDTH-1:0]      alu_res,
  input  logic [GPR_WIDTH-1:0]      imm,
  input  logic [GPR_WIDTH-1:0]      mem_addr,
  input  logic [GPR_WIDTH-1:0]      mem_data,
  input  logic [NUM_FLAGS-1:0]      flags,
  input  logic [GRP_ADDR_WIDTH-1:0] flag_code,
  input  logic [GRP_ADDR_WIDTH-1:0] reg_dest,
  mem_stage_if.master               dmem,
  output logic                      stall,
  output logic                      branch_taken,
  output logic [PC_WIDTH-1:0]       branch_target,
  output logic                      out_reg_write_enable,
  output logic [1:0]                out_wb_res_mux,
  output logic [GRP_ADDR_WIDTH-1:0] out_reg_dest,
  output logic [GPR_WIDTH-1:0]      out_alu_res,
  output logic [GPR_WIDTH-1:0]      out_mem_rdata,
  output logic [PC_WIDTH-1:0]       out_next_pc,
  output logic [GPR_WIDTH-1:0]      out_imm,
  output logic                      mem_fault,
  output mem_state_e                state_dbg
);

  mem_state_e state, state_nxt;
  logic       is_load;
  logic       access_needed;
  logic       cond;
  logic       timeout_hit;
  logic       req_c;
  logic       stall_c;
  logic       fault_bubble;
  logic       bubble;

  assign is_load       = (wb_res_mux == WB_RES_MEM);
  assign access_needed = mem_write_enable | is_load;

  branch_resolve u_branch_resolve (
    .flags            (flags),
    .flag_code        (flag_code),
    .sel_jflag_branch (sel_jflag_branch),
    .sel_jt_jf        (sel_jt_jf),
    .sel_beq_bne      (sel_beq_bne),
    .cond             (cond)
  );

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             mem_fault_q;

  // Counts completed WAIT cycles; the last allowed one fires the timeout.
  assign timeout_hit = (state == ST_WAIT) && !dmem.ready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && state_nxt == ST_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_fault_q <= 1'b0;
    end else if (state_nxt == ST_FAULT) begin
      mem_fault_q <= 1'b1;
    end
  end

  assign mem_fault = mem_fault_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (access_needed && !dmem.ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem.ready)       state_nxt = ST_IDLE;
        else if (timeout_hit) state_nxt = ST_FAULT;
      end
      ST_FAULT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // EX/MEM is frozen while stalled, so the request fields stay stable in WAIT.
  always_comb begin
    req_c        = 1'b0;
    stall_c      = 1'b0;
    fault_bubble = 1'b0;
    case (state)
      ST_IDLE: begin
        req_c   = access_needed;
        stall_c = access_needed & ~dmem.ready;
      end
      ST_WAIT: begin
        req_c   = 1'b1;
        stall_c = ~dmem.ready;
      end
      ST_FAULT: fault_bubble = 1'b1;
      default: begin
        req_c   = 1'b0;
        stall_c = 1'b0;
      end
    endcase
  end

  // Gating with rst drops the request as soon as reset asserts.
  assign dmem.req   = req_c & rst;
  assign dmem.we    = mem_write_enable;
  assign dmem.addr  = mem_addr[DATA_MEM_ADDR_WIDTH-1:0];
  assign dmem.wdata = mem_data;
  assign stall      = stall_c & rst;
  assign state_dbg  = state;

  assign branch_taken  = rst & is_branch & cond & ~stall_c;
  assign branch_target = branch_addr;

  assign bubble = stall_c | fault_bubble;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= '0;
      out_reg_dest         <= '0;
      out_alu_res          <= '0;
      out_mem_rdata        <= '0;
      out_next_pc          <= '0;
      out_imm              <= '0;
    end else if (bubble) begin
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= '0;
      out_reg_dest         <= '0;
      out_alu_res          <= '0;
      out_mem_rdata        <= '0;
      out_next_pc          <= '0;
      out_imm              <= '0;
    end else begin
      out_reg_write_enable <= reg_write_enable;
      out_wb_res_mux       <= wb_res_mux;
      out_reg_dest         <= reg_dest;
      out_alu_res          <= alu_res;
      out_mem_rdata        <= is_load ? dmem.rdata : '0;
      out_next_pc          <= next_pc;
      out_imm              <= imm;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, stores, loads with wait
// states, branch resolution, reset during WAIT and the timeout option.
module tb_mem_stage;
  import lapido_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      mem_write_enable, sel_beq_bne, sel_jt_jf;
  logic                      is_branch, sel_jflag_branch, reg_write_enable;
  logic [1:0]                wb_res_mux;
  logic [PC_WIDTH-1:0]       branch_addr, next_pc;
  logic [GPR_WIDTH-1:0]      alu_res, imm, mem_addr, mem_data;
  logic [NUM_FLAGS-1:0]      flags;
  logic [GRP_ADDR_WIDTH-1:0] flag_code, reg_dest;
  logic                      stall, branch_taken, mem_fault;
  logic [PC_WIDTH-1:0]       branch_target;
  logic                      out_reg_write_enable;
  logic [1:0]                out_wb_res_mux;
  logic [GRP_ADDR_WIDTH-1:0] out_reg_dest;
  logic [GPR_WIDTH-1:0]      out_alu_res, out_mem_rdata, out_imm;
  logic [PC_WIDTH-1:0]       out_next_pc;
  mem_state_e                state_dbg;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_write_enable(mem_write_enable), .sel_beq_bne(sel_beq_bne),
    .sel_jt_jf(sel_jt_jf), .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
    .wb_res_mux(wb_res_mux), .reg_write_enable(reg_write_enable),
    .branch_addr(branch_addr), .next_pc(next_pc), .alu_res(alu_res), .imm(imm),
    .mem_addr(mem_addr), .mem_data(mem_data), .flags(flags), .flag_code(flag_code),
    .reg_dest(reg_dest), .dmem(dmem), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .out_reg_write_enable(out_reg_write_enable),
    .out_wb_res_mux(out_wb_res_mux), .out_reg_dest(out_reg_dest),
    .out_alu_res(out_alu_res), .out_mem_rdata(out_mem_rdata),
    .out_next_pc(out_next_pc), .out_imm(out_imm), .mem_fault(mem_fault),
    .state_dbg(state_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [GPR_WIDTH-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    mem_write_enable = 1'b0; sel_beq_bne = 1'b0; sel_jt_jf = 1'b0;
    is_branch = 1'b0; sel_jflag_branch = 1'b0; reg_write_enable = 1'b0;
    wb_res_mux = WB_RES_ALU; branch_addr = '0; next_pc = '0; alu_res = '0;
    imm = '0; mem_addr = '0; mem_data = '0; flags = '0; flag_code = '0;
    reg_dest = '0; dmem.ready = 1'b0; dmem.rdata = '0;
  endtask

  // Lands 1 time unit after the rising edge: registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [GPR_WIDTH-1:0] addr,
                            input logic [GRP_ADDR_WIDTH-1:0] dest);
    wb_res_mux = WB_RES_MEM; reg_write_enable = 1'b1;
    mem_addr = addr; reg_dest = dest; mem_write_enable = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    mem_write_enable = 1'b1;
    repeat (2) tick();
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", dmem.req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", mem_fault); end
    checks++; if ({out_reg_write_enable, out_wb_res_mux, out_reg_dest, out_alu_res, out_mem_rdata, out_next_pc, out_imm} !== '0)
      begin failures++; $display("FAIL reset_memwb: got we=%b alu=%h rdata=%h", out_reg_write_enable, out_alu_res, out_mem_rdata); end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu_passthrough();
    reg_write_enable = 1'b1; wb_res_mux = WB_RES_ALU; reg_dest = 4'd7;
    alu_res = 16'h5A5A; next_pc = 16'h0101; imm = 16'h0077;
    dmem.ready = 1'b1; dmem.rdata = 16'hBEEF;  // ready without req must be ignored
    #1;
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL alu_req: got %b want 0", dmem.req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    checks++; if (out_alu_res !== 16'h5A5A) begin failures++; $display("FAIL alu_res: got %h want 5a5a", out_alu_res); end
    checks++; if (out_mem_rdata !== 16'h0000) begin failures++; $display("FAIL alu_rdata: got %h want 0000", out_mem_rdata); end
    checks++; if (out_reg_write_enable !== 1'b1 || out_reg_dest !== 4'd7) begin failures++; $display("FAIL alu_wb: got we=%b dest=%0d want 1/7", out_reg_write_enable, out_reg_dest); end
    checks++; if (out_next_pc !== 16'h0101 || out_imm !== 16'h0077) begin failures++; $display("FAIL alu_pc_imm: got %h/%h want 0101/0077", out_next_pc, out_imm); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL alu_state: got %0d want %0d", state_dbg, ST_IDLE); end
    clear_inputs();
  endtask

  task automatic test_store_zero_wait();
    mem_write_enable = 1'b1; mem_addr = 16'h0010; mem_data = 16'hCAFE;
    alu_res = 16'h0010; dmem.ready = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1) begin failures++; $display("FAIL store_req: got req=%b we=%b want 1/1", dmem.req, dmem.we); end
    checks++; if (dmem.addr !== 16'h0010 || dmem.wdata !== 16'hCAFE) begin failures++; $display("FAIL store_bus: got %h/%h want 0010/cafe", dmem.addr, dmem.wdata); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL store_stall: got %b want 0", stall); end
    tick();
    clear_inputs();
    #1;
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL store_req_drop: got %b want 0", dmem.req); end
    checks++; if (out_reg_write_enable !== 1'b0 || out_mem_rdata !== '0) begin failures++; $display("FAIL store_memwb: got we=%b rdata=%h want 0/0", out_reg_write_enable, out_mem_rdata); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL store_state: got %0d want %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_load_wait3();
    int stall_cycles = 0;
    drive_load(16'h0020, 4'd3);
    dmem.rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall === 1'b1) stall_cycles++;
      checks++; if (dmem.req !== 1'b1 || dmem.addr !== 16'h0020) begin failures++; $display("FAIL load_req_hold: cycle %0d got req=%b addr=%h want 1/0020", i, dmem.req, dmem.addr); end
      tick();
      checks++; if (out_reg_write_enable !== 1'b0 || out_mem_rdata !== '0) begin failures++; $display("FAIL load_bubble: cycle %0d got we=%b rdata=%h want 0/0", i, out_reg_write_enable, out_mem_rdata); end
    end
    checks++; if (stall_cycles != 3) begin failures++; $display("FAIL load_stall_count: got %0d want 3", stall_cycles); end
    checks++; if (state_dbg !== ST_WAIT) begin failures++; $display("FAIL load_in_wait: got %0d want %0d", state_dbg, ST_WAIT); end
    dmem.ready = 1'b1; dmem.rdata = 16'h1234;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_release: got stall=%b want 0", stall); end
    tick();
    clear_inputs();
    checks++; if (out_mem_rdata !== 16'h1234) begin failures++; $display("FAIL load_rdata: got %h want 1234", out_mem_rdata); end
    checks++; if (out_reg_write_enable !== 1'b1 || out_reg_dest !== 4'd3 || out_wb_res_mux !== WB_RES_MEM) begin failures++; $display("FAIL load_wb: got we=%b dest=%0d mux=%0d want 1/3/1", out_reg_write_enable, out_reg_dest, out_wb_res_mux); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL load_state: got %0d want %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [GPR_WIDTH-1:0] exp;
    drive_load(16'h0030, 4'd1); dmem.ready = 1'b1; dmem.rdata = 16'h1111;
    exp_q.push_back(16'h1111);
    tick();
    checks++; exp = exp_q.pop_front();
    if (out_mem_rdata !== exp || out_reg_dest !== 4'd1) begin failures++; $display("FAIL b2b_first: got %h dest=%0d want %h dest=1", out_mem_rdata, out_reg_dest, exp); end
    drive_load(16'h0031, 4'd2); dmem.rdata = 16'h2222;
    exp_q.push_back(16'h2222);
    #1;
    checks++; if (stall !== 1'b0 || dmem.addr !== 16'h0031) begin failures++; $display("FAIL b2b_second_req: got stall=%b addr=%h want 0/0031", stall, dmem.addr); end
    tick();
    clear_inputs();
    checks++; exp = exp_q.pop_front();
    if (out_mem_rdata !== exp || out_reg_dest !== 4'd2) begin failures++; $display("FAIL b2b_second: got %h dest=%0d want %h dest=2", out_mem_rdata, out_reg_dest, exp); end
  endtask

  task automatic test_branch();
    is_branch = 1'b1; branch_addr = 16'h0040; flags = 6'b010000;
    #1;
    checks++; if (branch_taken !== 1'b1 || branch_target !== 16'h0040) begin failures++; $display("FAIL beq_taken: got %b tgt=%h want 1/0040", branch_taken, branch_target); end
    sel_beq_bne = 1'b1; #1;
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL bne_zero_set: got %b want 0", branch_taken); end
    flags = 6'b000000; #1;
    checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL bne_zero_clr: got %b want 1", branch_taken); end
    sel_beq_bne = 1'b0; sel_jflag_branch = 1'b1; sel_jt_jf = 1'b1;
    flag_code = 4'd5; flags = 6'b011111; #1;
    checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL jf_carry: got %b want 1", branch_taken); end
    sel_jt_jf = 1'b0; flag_code = 4'd7; flags = 6'b111111; #1;
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL jt_code7: got %b want 0", branch_taken); end
    flag_code = 4'd1; flags = 6'b000010; #1;
    checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL jt_true: got %b want 1", branch_taken); end
    is_branch = 1'b0; #1;
    checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL not_branch: got %b want 0", branch_taken); end
    clear_inputs();
  endtask

  task automatic test_branch_with_access();
    is_branch = 1'b1; branch_addr = 16'h0080; flags = 6'b010000;
    drive_load(16'h0044, 4'd5);
    #1;
    checks++; if (branch_taken !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL br_acc_hold: got taken=%b stall=%b want 0/1", branch_taken, stall); end
    tick();
    dmem.ready = 1'b1; dmem.rdata = 16'h00AA;
    #1;
    checks++; if (branch_taken !== 1'b1 || branch_target !== 16'h0080) begin failures++; $display("FAIL br_acc_done: got taken=%b tgt=%h want 1/0080", branch_taken, branch_target); end
    tick();
    clear_inputs();
    checks++; if (out_mem_rdata !== 16'h00AA) begin failures++; $display("FAIL br_acc_rdata: got %h want 00aa", out_mem_rdata); end
  endtask

  task automatic test_reset_during_wait();
    mem_write_enable = 1'b1; mem_addr = 16'h0050; mem_data = 16'h7777;
    tick();
    checks++; if (state_dbg !== ST_WAIT) begin failures++; $display("FAIL rwait_entered: got %0d want %0d", state_dbg, ST_WAIT); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rwait_async: got req=%b stall=%b want 0/0", dmem.req, stall); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL rwait_state: got %0d want %0d", state_dbg, ST_IDLE); end
    checks++; if ({out_reg_write_enable, out_alu_res, out_mem_rdata, out_next_pc, out_imm} !== '0) begin failures++; $display("FAIL rwait_memwb: got we=%b alu=%h", out_reg_write_enable, out_alu_res); end
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
    checks++; if (state_dbg !== ST_IDLE || dmem.req !== 1'b0) begin failures++; $display("FAIL rwait_release: got state=%0d req=%b want %0d/0", state_dbg, dmem.req, ST_IDLE); end
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout();
    drive_load(16'h0060, 4'd4);
    repeat (4) tick();  // IDLE cycle plus three WAIT cycles
    checks++; if (mem_fault !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL to_early: got fault=%b stall=%b want 0/1", mem_fault, stall); end
    tick();  // fourth WAIT cycle expires
    checks++; if (state_dbg !== ST_FAULT || mem_fault !== 1'b1) begin failures++; $display("FAIL to_fault: got state=%0d fault=%b want %0d/1", state_dbg, mem_fault, ST_FAULT); end
    checks++; if (stall !== 1'b0 || dmem.req !== 1'b0) begin failures++; $display("FAIL to_release: got stall=%b req=%b want 0/0", stall, dmem.req); end
    clear_inputs();
    tick();
    checks++; if (state_dbg !== ST_IDLE || out_reg_write_enable !== 1'b0) begin failures++; $display("FAIL to_idle: got state=%0d we=%b want %0d/0", state_dbg, out_reg_write_enable, ST_IDLE); end
    repeat (5) tick();
    checks++; if (mem_fault !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", mem_fault); end
    rst = 1'b0; #1;
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL to_clear: got %b want 0", mem_fault); end
    tick(); rst = 1'b1; tick();
  endtask
`else
  task automatic test_timeout();
    drive_load(16'h0060, 4'd4);
    repeat (20) tick();
    checks++; if (stall !== 1'b1 || state_dbg !== ST_WAIT) begin failures++; $display("FAIL nto_wait: got stall=%b state=%0d want 1/%0d", stall, state_dbg, ST_WAIT); end
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL nto_fault: got %b want 0", mem_fault); end
    dmem.ready = 1'b1; dmem.rdata = 16'h0F0F;
    tick();
    clear_inputs();
    checks++; if (out_mem_rdata !== 16'h0F0F || state_dbg !== ST_IDLE) begin failures++; $display("FAIL nto_done: got %h state=%0d want 0f0f/%0d", out_mem_rdata, state_dbg, ST_IDLE); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_passthrough();
    test_store_zero_wait();
    test_load_wait3();
    test_back_to_back();
    test_branch();
    test_branch_with_access();
    test_reset_during_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
